// File: rtl/avalon_game_reg_master.sv
// Avalon-MM block master for the 64x32 game register slave.
// Runs one write/read block command at a time against the word-addressed bus.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   CMD_VALID/READY   command handshake; CMD_WRITE, CMD_BASE, CMD_COUNT
//   WR_DATA/VALID/READY  write-data stream into the master
//   RD_DATA/VALID     read-data stream out (no backpressure)
//   DONE, ERR         end-of-command pulse, ERR set on timeout abort
//   AVM_*             Avalon-MM master interface
module avalon_game_reg_master #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_BASE,
  input  logic [ADDR_W:0]   CMD_COUNT,
  input  logic [31:0]       WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic              AVM_CS,
  output logic              AVM_READ,
  output logic              AVM_WRITE,
  output logic [3:0]        AVM_BYTE_EN,
  output logic [31:0]       AVM_WRITEDATA,
  input  logic [31:0]       AVM_READDATA,
  input  logic              AVM_WAITREQUEST
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_BUS,
    RD_BUS,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx_q;
  logic [31:0]       wdata_q;
  logic [15:0]       to_q;
  logic              err_q;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;

  logic              on_bus;
  logic              xfer;
  logic              tmo;
  logic              last;
  logic [ADDR_W-1:0] addr;

  assign on_bus = (state_q == WR_BUS) || (state_q == RD_BUS);
  assign xfer   = on_bus && !AVM_WAITREQUEST;
  assign tmo    = on_bus && AVM_WAITREQUEST && (to_q == TO_LAST);
  assign last   = (idx_q == count_q - ONE);
  // Truncating add gives the wrap from the top of the register space to 0.
  assign addr   = base_q + idx_q[ADDR_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          if (CMD_COUNT == '0) state_d = FINISH;
          else if (CMD_WRITE)  state_d = WR_FETCH;
          else                 state_d = RD_BUS;
        end
      end
      WR_FETCH: begin
        if (WR_VALID) state_d = WR_BUS;
      end
      WR_BUS: begin
        if (tmo)       state_d = FINISH;
        else if (xfer) state_d = last ? FINISH : WR_FETCH;
      end
      RD_BUS: begin
        if (tmo)               state_d = FINISH;
        else if (xfer && last) state_d = FINISH;
      end
      FINISH: begin
        // Hold until the last read word has been presented, so DONE
        // follows the final RD_VALID.
        if (!rd_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY     = 1'b0;
    WR_READY      = 1'b0;
    RD_DATA       = '0;
    RD_VALID      = 1'b0;
    DONE          = 1'b0;
    ERR           = 1'b0;
    AVM_ADDR      = '0;
    AVM_CS        = 1'b0;
    AVM_READ      = 1'b0;
    AVM_WRITE     = 1'b0;
    AVM_BYTE_EN   = 4'h0;
    AVM_WRITEDATA = '0;
    // Reset gates every output so the bus drops in the reset cycle itself.
    if (!RESET) begin
      RD_DATA  = rd_data_q;
      RD_VALID = rd_valid_q;
      unique case (state_q)
        IDLE:     CMD_READY = 1'b1;
        WR_FETCH: WR_READY = 1'b1;
        WR_BUS: begin
          AVM_CS        = 1'b1;
          AVM_WRITE     = 1'b1;
          AVM_ADDR      = addr;
          AVM_BYTE_EN   = 4'hF;
          AVM_WRITEDATA = wdata_q;
        end
        RD_BUS: begin
          AVM_CS      = 1'b1;
          AVM_READ    = 1'b1;
          AVM_ADDR    = addr;
          AVM_BYTE_EN = 4'hF;
        end
        FINISH: begin
          DONE = !rd_valid_q;
          ERR  = !rd_valid_q && err_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (CMD_VALID) begin
            base_q  <= CMD_BASE;
            count_q <= CMD_COUNT;
            idx_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
          end
        end
        WR_FETCH: begin
          if (WR_VALID) wdata_q <= WR_DATA;
        end
        WR_BUS, RD_BUS: begin
          if (xfer) begin
            to_q  <= '0;
            idx_q <= idx_q + ONE;
            if (state_q == RD_BUS) begin
              rd_data_q  <= AVM_READDATA;
              rd_valid_q <= 1'b1;
            end
          end else begin
            to_q <= to_q + 16'd1;
            if (tmo) err_q <= 1'b1;
          end
        end
        FINISH: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_game_reg_master.sv
// Scoreboard bench for avalon_game_reg_master.
// Directed commands push expectations; a negedge monitor pops and compares.
module tb_avalon_game_reg_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WRITE = 1'b0;
  logic [5:0]  CMD_BASE = '0;
  logic [6:0]  CMD_COUNT = '0;
  logic [31:0] WR_DATA = '0;
  logic        WR_VALID = 1'b0;
  logic        WR_READY;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic        DONE;
  logic        ERR;
  logic [5:0]  AVM_ADDR;
  logic        AVM_CS;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA;
  logic        AVM_WAITREQUEST;

  avalon_game_reg_master #(.TIMEOUT(4), .ADDR_W(6)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_BASE(CMD_BASE),
    .CMD_COUNT(CMD_COUNT),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .DONE(DONE), .ERR(ERR),
    .AVM_ADDR(AVM_ADDR), .AVM_CS(AVM_CS),
    .AVM_READ(AVM_READ), .AVM_WRITE(AVM_WRITE),
    .AVM_BYTE_EN(AVM_BYTE_EN),
    .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_READDATA(AVM_READDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    logic err;
    bit   from_acc;
    int   gap;
    int   cs;
  } done_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  done_t       done_q[$];
  logic [31:0] wrq[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  localparam logic [5:0] STALL_ADDR = 6'd21;
  logic [31:0] mem [64] = '{default: 32'h0};
  logic        stuck = 1'b0;
  int          stall_cnt = 0;

  assign AVM_READDATA = mem[AVM_ADDR];
  assign AVM_WAITREQUEST = stuck ||
    (AVM_CS && AVM_ADDR == STALL_ADDR && stall_cnt < 3);

  always @(posedge CLK) begin
    if (AVM_WRITE && !AVM_WAITREQUEST)
      mem[AVM_ADDR] <= AVM_WRITEDATA;
    if (AVM_CS && AVM_WAITREQUEST && !stuck)
      stall_cnt <= stall_cnt + 1;
  end

  always @(posedge CLK) begin
    if (WR_VALID && WR_READY) void'(wrq.pop_front());
    #1;
    WR_VALID = (wrq.size() != 0);
    WR_DATA  = (wrq.size() != 0) ? wrq[0] : 32'h0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int   cyc = 0;
  int   cs_cnt = 0;
  int   last_cs = 0;
  int   acc_cyc = 0;
  bit   prev_stall = 0;
  bus_t prev;

  always @(negedge CLK) begin
    bus_t  b;
    done_t d;
    logic  ok;
    cyc++;
    if (RESET) begin
      cs_cnt = 0;
      prev_stall = 0;
    end else begin
      ok = (AVM_CS == (AVM_READ | AVM_WRITE)) &&
           !(AVM_READ && AVM_WRITE) &&
           (AVM_BYTE_EN == (AVM_CS ? 4'hF : 4'h0)) &&
           !(WR_READY && AVM_CS) &&
           !(CMD_READY && (AVM_CS || WR_READY || DONE));
      chk("protocol", ok, 1'b1);
      if (CMD_VALID && CMD_READY) begin
        acc_cyc = cyc;
        cs_cnt = 0;
      end
      if (AVM_CS) begin
        if (prev_stall) begin
          chk("hold_addr", AVM_ADDR, prev.addr);
          chk("hold_wr", AVM_WRITE, prev.wr);
          chk("hold_data", AVM_WRITEDATA, prev.data);
        end
        cs_cnt++;
        last_cs = cyc;
        if (!AVM_WAITREQUEST) begin
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL bus_unexpected: got addr %0d", AVM_ADDR);
          end else begin
            b = bus_q.pop_front();
            chk("bus_wr", AVM_WRITE, b.wr);
            chk("bus_addr", AVM_ADDR, b.addr);
            if (b.wr) chk("bus_wdata", AVM_WRITEDATA, b.data);
          end
        end
        prev_stall = AVM_WAITREQUEST;
        prev.addr = AVM_ADDR;
        prev.wr = AVM_WRITE;
        prev.data = AVM_WRITEDATA;
      end else begin
        prev_stall = 0;
      end
      if (RD_VALID) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got %h", RD_DATA);
        end else chk("rd_data", RD_DATA, rd_q.pop_front());
      end
      if (DONE) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: got DONE, none expected");
        end else begin
          d = done_q.pop_front();
          chk("done_err", ERR, d.err);
          chk("done_cs_cycles", cs_cnt, d.cs);
          chk("done_gap", cyc - (d.from_acc ? acc_cyc : last_cs), d.gap);
        end
      end else if (ERR) begin
        tests++; fails++;
        $display("FAIL err_without_done: got ERR=1 expected 0");
      end
    end
  end

  task automatic push_bus(input logic w, input logic [5:0] a,
                          input logic [31:0] dt);
    bus_t b;
    b.wr = w; b.addr = a; b.data = dt;
    bus_q.push_back(b);
  endtask

  task automatic push_done(input logic e, input bit fa,
                           input int g, input int c);
    done_t d;
    d.err = e; d.from_acc = fa; d.gap = g; d.cs = c;
    done_q.push_back(d);
  endtask

  task automatic issue(input logic w, input logic [5:0] b,
                       input logic [6:0] c);
    int n = 0;
    @(posedge CLK); #1;
    CMD_WRITE = w; CMD_BASE = b; CMD_COUNT = c; CMD_VALID = 1'b1;
    @(negedge CLK);
    while (!CMD_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!CMD_READY) begin
      fails++;
      $display("FAIL cmd_accept: got READY=0 expected 1");
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge CLK);
      n++;
    end
    chk("done_seen", done_cnt, target);
  endtask

  task automatic run(input logic w, input logic [5:0] b,
                     input logic [6:0] c);
    int t = done_cnt + 1;
    issue(w, b, c);
    wait_done(t);
  endtask

  initial begin
    int n;
    chk("rst_ready", CMD_READY, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK); #1;
    chk("rst_cmd_ready", CMD_READY, 1'b1);
    chk("rst_cs", AVM_CS, 1'b0);
    chk("rst_wr_ready", WR_READY, 1'b0);
    chk("rst_done", {DONE, ERR, RD_VALID}, 3'b000);

    // write 5..7
    wrq.push_back(32'hA0); wrq.push_back(32'hA1);
    wrq.push_back(32'hA2);
    push_bus(1, 5, 32'hA0); push_bus(1, 6, 32'hA1);
    push_bus(1, 7, 32'hA2);
    push_done(0, 0, 1, 3);
    run(1, 5, 3);
    chk("mem5", mem[5], 32'hA0);
    chk("mem7", mem[7], 32'hA2);

    // read back 5..7
    push_bus(0, 5, 0); push_bus(0, 6, 0); push_bus(0, 7, 0);
    rd_q.push_back(32'hA0); rd_q.push_back(32'hA1);
    rd_q.push_back(32'hA2);
    push_done(0, 0, 2, 3);
    run(0, 5, 3);

    // wrapping write 62,63,0,1
    wrq.push_back(32'h11); wrq.push_back(32'h22);
    wrq.push_back(32'h33); wrq.push_back(32'h44);
    push_bus(1, 62, 32'h11); push_bus(1, 63, 32'h22);
    push_bus(1, 0, 32'h33); push_bus(1, 1, 32'h44);
    push_done(0, 0, 1, 4);
    run(1, 62, 4);
    chk("mem0", mem[0], 32'h33);
    chk("mem1", mem[1], 32'h44);

    // zero-length command
    push_done(0, 1, 1, 0);
    run(1, 10, 0);

    // 3 stall cycles on word 1
    wrq.push_back(32'hB0); wrq.push_back(32'hB1);
    push_bus(1, 20, 32'hB0); push_bus(1, 21, 32'hB1);
    push_done(0, 0, 1, 5);
    run(1, 20, 2);
    chk("mem21", mem[21], 32'hB1);

    // read timeout
    @(posedge CLK); #1 stuck = 1'b1;
    push_done(1, 0, 1, 4);
    run(0, 30, 2);
    @(posedge CLK); #1 stuck = 1'b0;

    // reset during WR_BUS
    wrq.push_back(32'hC0);
    @(posedge CLK); #1 stuck = 1'b1;
    issue(1, 40, 1);
    n = 0;
    while (!AVM_WRITE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_wr_bus", AVM_WRITE, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_bus_drop", {AVM_CS, AVM_WRITE}, 2'b00);
    @(posedge CLK); #1;
    RESET = 1'b0;
    stuck = 1'b0;
    @(negedge CLK); #1;
    chk("post_rst_ready", CMD_READY, 1'b1);
    chk("post_rst_bus", {AVM_CS, AVM_READ, AVM_WRITE}, 3'b000);
    chk("post_rst_addr", AVM_ADDR, 6'd0);
    chk("post_rst_wdata", AVM_WRITEDATA, 32'h0);
    chk("post_rst_misc", {WR_READY, DONE, ERR, RD_VALID}, 4'h0);
    chk("mem40", mem[40], 32'h0);

    // new command after reset: read 62,63
    push_bus(0, 62, 0); push_bus(0, 63, 0);
    rd_q.push_back(32'h11); rd_q.push_back(32'h22);
    push_done(0, 0, 2, 2);
    run(0, 62, 2);

    repeat (5) @(posedge CLK);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
